// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame shifted on the
// device clock, device ACK check, and a watchdog on every protocol phase.
module ps2_tx #(
   parameter int unsigned INHIBIT_CYCLES = 2600,
   parameter int unsigned SETUP_CYCLES   = 25,
   parameter int unsigned TIMEOUT_CYCLES = 400000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_data,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   input  logic       i_ps2_clk_in,
   input  logic       i_ps2_data_in,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_data_oe
);

   localparam int unsigned MAX_IS  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SETUP,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit_cnt;
   logic [8:0]       r_shift;
   logic [1:0]       r_clk_sync;
   logic [1:0]       r_data_sync;
   logic             r_clk_prev;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic             r_clk_oe;
   logic             r_data_oe;

   logic w_clk_s;
   logic w_data_s;
   logic w_fall;
   logic w_watch;
   logic w_lines_idle;
   logic w_tmo;
   logic w_nack;
   logic w_abort;

   // Pin synchronizers; idle-high reset value avoids a false edge after reset
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_ps2_clk_in};
         r_data_sync <= {r_data_sync[0], i_ps2_data_in};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   assign w_clk_s      = r_clk_sync[1];
   assign w_data_s     = r_data_sync[1];
   assign w_fall       = r_clk_prev & ~w_clk_s;
   assign w_lines_idle = w_clk_s & w_data_s;
   assign w_watch      = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
   assign w_tmo        = w_watch && !w_fall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                         && !((r_state == S_WAIT_IDLE) && w_lines_idle);
   assign w_nack       = (r_state == S_ACK) && w_fall && w_data_s;
   assign w_abort      = w_tmo || w_nack;

   // r_cnt serves as the inhibit/setup timer and, from SEND onward, the watchdog
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (w_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // A start coinciding with the done/error pulse is dropped
                  if (i_start && !r_done && !r_error) begin
                     r_shift   <= {~^i_data, i_data};
                     r_cnt     <= '0;
                     r_bit_cnt <= '0;
                     r_busy    <= 1'b1;
                     r_clk_oe  <= 1'b1;
                     r_data_oe <= 1'b0;
                     r_state   <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                     r_cnt     <= '0;
                     r_data_oe <= 1'b1;
                     r_state   <= S_SETUP;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_SETUP: begin
                  if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                     r_cnt     <= '0;
                     r_bit_cnt <= '0;
                     r_clk_oe  <= 1'b0;
                     r_state   <= S_SEND;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_SEND: begin
                  if (w_fall) begin
                     r_cnt     <= '0;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd9) begin
                        r_data_oe <= 1'b0;
                        r_state   <= S_ACK;
                     end else begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[8:1]};
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_ACK: begin
                  if (w_fall) begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT_IDLE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_WAIT_IDLE: begin
                  if (w_lines_idle) begin
                     r_cnt   <= '0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else if (w_fall) begin
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_error       = r_error;
   assign o_ps2_clk_oe  = r_clk_oe;
   assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: wired-AND bus with a behavioural PS/2 device, table-driven and
// random transfers, plus timing, timeout, reset and busy-start sequences.
module tb_ps2_tx;

   localparam int unsigned INH  = 10;
   localparam int unsigned SET  = 3;
   localparam int unsigned TMO  = 100;
   localparam int unsigned HALF = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] data;
   logic       busy, done, error, clk_oe, data_oe;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;
   int n_err  = 0;

   assign ps2_clk_in  = ~clk_oe & dev_clk;
   assign ps2_data_in = ~data_oe & dev_data;

   ps2_tx #(
      .INHIBIT_CYCLES(INH),
      .SETUP_CYCLES  (SET),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_data       (data),
      .i_start      (start),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error),
      .i_ps2_clk_in (ps2_clk_in),
      .i_ps2_data_in(ps2_data_in),
      .o_ps2_clk_oe (clk_oe),
      .o_ps2_data_oe(data_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         nack;
      logic       exp_par;
   } vec_t;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Expected line levels seen by the device: start, LSB-first data, odd parity, stop
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int          ones;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         ones   = ones + int'(d[i]);
      end
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   always @(negedge clk) begin
      if (done || error) begin
         if (done)  n_done++;
         if (error) n_err++;
         chk1("done_error_exclusive", done & error, 1'b0);
         chk1("busy_low_at_pulse", busy, 1'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic dev_wait_send(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (busy && data_oe && !clk_oe) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic dev_edge(output logic smp);
      dev_clk = 1'b0;
      ticks(HALF);
      dev_clk = 1'b1;
      smp = ps2_data_in;
      ticks(HALF);
   endtask

   task automatic xfer(input logic [7:0] d, input bit nack, input bit poke, output logic [10:0] got);
      bit   ok;
      bit   seen;
      logic s;
      int   d0, e0;
      got  = '0;
      d0   = n_done;
      e0   = n_err;
      data = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      data  = 8'($urandom);
      dev_wait_send(ok);
      chk1($sformatf("reach_send_%02h", d), ok, 1'b1);
      if (!ok) return;
      ticks(4);
      got[0] = ps2_data_in;
      for (int i = 1; i <= 10; i++) begin
         if (poke && i == 5) begin
            data  = 8'h55;
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         dev_edge(s);
         got[i] = s;
      end
      // ACK slot: device drives data (low = ACK) before the 11th falling edge
      dev_data = nack;
      ticks(2);
      dev_clk = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (i == int'(HALF))     dev_clk  = 1'b1;
         if (i == int'(HALF) + 3) dev_data = 1'b1;
         if (done || error) seen = 1'b1;
      end
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      chk1($sformatf("end_pulse_seen_%02h", d), seen, 1'b1);
      if (seen) begin
         // start presented in the pulse cycle must not launch a transfer
         data  = 8'h3C;
         start = 1'b1;
         tick();
         start = 1'b0;
         chk1($sformatf("start_in_pulse_ignored_%02h", d), busy, 1'b0);
         ticks(3);
         chk1($sformatf("idle_busy_%02h", d), busy, 1'b0);
         chk1($sformatf("idle_clk_oe_%02h", d), clk_oe, 1'b0);
         chk1($sformatf("idle_data_oe_%02h", d), data_oe, 1'b0);
      end
      chk32($sformatf("frame_%02h", d), 32'(got), 32'(model_frame(d)));
      chk32($sformatf("done_count_%02h", d), 32'(n_done - d0), nack ? 32'd0 : 32'd1);
      chk32($sformatf("error_count_%02h", d), 32'(n_err - e0), nack ? 32'd1 : 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL global_time_limit: got expired, want finish");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t        tbl [5];
      logic [10:0] got;
      logic        s;
      bit          ok;
      int          cyc, d0, e0;

      tbl[0] = '{d: 8'hED, nack: 1'b0, exp_par: 1'b1};
      tbl[1] = '{d: 8'h01, nack: 1'b0, exp_par: 1'b0};
      tbl[2] = '{d: 8'h00, nack: 1'b0, exp_par: 1'b1};
      tbl[3] = '{d: 8'h00, nack: 1'b1, exp_par: 1'b1};
      tbl[4] = '{d: 8'h01, nack: 1'b1, exp_par: 1'b0};

      reset = 1'b1;
      start = 1'b0;
      data  = 8'h00;
      ticks(3);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_error", error, 1'b0);
      chk1("reset_clk_oe", clk_oe, 1'b0);
      chk1("reset_data_oe", data_oe, 1'b0);
      reset = 1'b0;
      ticks(2);

      for (int k = 0; k < 5; k++) begin
         xfer(tbl[k].d, tbl[k].nack, 1'b0, got);
         chk1($sformatf("parity_%0d", k), got[9], tbl[k].exp_par);
      end

      // Inhibit/setup timing, then timeout with the device silent
      d0    = n_done;
      data  = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         chk1($sformatf("timing_clk_oe_T+%0d", c), clk_oe, (c <= 13));
         chk1($sformatf("timing_data_oe_T+%0d", c), data_oe, (c >= 11));
         if (c == 1) chk1("timing_busy_T+1", busy, 1'b1);
         if (c < 14) tick();
      end
      cyc = 14;
      while (!error && cyc < 300) begin
         tick();
         cyc++;
      end
      chk32("timeout_cycle", 32'(cyc), 32'(14 + TMO));
      chk1("timeout_busy", busy, 1'b0);
      chk1("timeout_clk_oe", clk_oe, 1'b0);
      chk1("timeout_data_oe", data_oe, 1'b0);
      ticks(3);
      chk32("timeout_no_done", 32'(n_done - d0), 32'd0);
      xfer(8'hC3, 1'b0, 1'b0, got);

      // Reset after the 5th falling edge
      d0    = n_done;
      e0    = n_err;
      data  = 8'hED;
      start = 1'b1;
      tick();
      start = 1'b0;
      dev_wait_send(ok);
      chk1("rst_reach_send", ok, 1'b1);
      ticks(4);
      for (int i = 1; i <= 4; i++) dev_edge(s);
      dev_clk = 1'b0;
      ticks(6);
      chk1("rst_pre_busy", busy, 1'b1);
      chk1("rst_pre_data_oe", data_oe, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk1("rst_async_clk_oe", clk_oe, 1'b0);
      chk1("rst_async_data_oe", data_oe, 1'b0);
      chk1("rst_async_busy", busy, 1'b0);
      dev_clk = 1'b1;
      ticks(3);
      reset = 1'b0;
      ticks(5);
      chk32("rst_no_done", 32'(n_done - d0), 32'd0);
      chk32("rst_no_error", 32'(n_err - e0), 32'd0);
      xfer(8'hFF, 1'b0, 1'b0, got);

      // start with other data while a frame is in flight
      xfer(8'hF4, 1'b0, 1'b1, got);

      for (int r = 0; r < 8; r++) begin
         logic [7:0] rd;
         bit         rn;
         rd = 8'($urandom_range(0, 255));
         rn = ($urandom_range(0, 3) == 0);
         xfer(rd, rn, 1'($urandom_range(0, 1)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example LED control (0xED) or reset (0xFF), over the same open-collector `ps2_clk`/`ps2_data` pair that the keyboard receiver in `memory` listens on. It performs the host request-to-send sequence, shifts out one 11-bit frame on the device-generated clock, and checks the device acknowledge bit. The top level builds the open-collector drivers from the `*_oe` outputs: pin = `oe ? 0 : 1'bz`.

## Interface
- `INHIBIT_CYCLES`, 2600: cycles `ps2_clk` is held low before a request (≥100 µs at 25 MHz).
- `SETUP_CYCLES`, 25: cycles both lines are held low before `ps2_clk` is released.
- `TIMEOUT_CYCLES`, 400000: watchdog limit between protocol events (~16 ms).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `data` in 8: byte to send; sampled when `start` is accepted.
- `start` in 1: one-cycle request; ignored while `busy`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`/`error` is issued.
- `done` out 1: one-cycle pulse; the frame was sent and ACK received.
- `error` out 1: one-cycle pulse; NACK or timeout.
- `ps2_clk_in` in 1: raw clock pin level, asynchronous.
- `ps2_data_in` in 1: raw data pin level, asynchronous.
- `ps2_clk_oe` out 1: 1 pulls `ps2_clk` low.
- `ps2_data_oe` out 1: 1 pulls `ps2_data` low.

## Operation
- **Input conditioning**
  - Each of `ps2_clk_in` and `ps2_data_in` goes through a 2-flop synchronizer.
  - A falling edge is a synchronized clock that was 1 on the previous cycle and is 0 on this cycle.
- **Frame:** start bit 0, `data[0]`..`data[7]` (LSB first), odd parity (`~^data`), stop bit 1, then the device ACK bit.
- **IDLE**
  - All outputs are 0.
  - `start` latches `data` into the shift register, computes parity and goes to INHIBIT.
- **INHIBIT**
  - `ps2_clk_oe`=1, `ps2_data_oe`=0 for exactly `INHIBIT_CYCLES` cycles, then go to SETUP.
- **SETUP**
  - `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit) for `SETUP_CYCLES` cycles, then go to SEND.
  - On entry to SEND: bit counter = 0, watchdog cleared.
- **SEND**
  - `ps2_clk_oe`=0.
  - On each falling edge, present the next bit: `ps2_data_oe` = ~bit.
  - Edges 1–8 present data bits 0–7, edge 9 presents parity, edge 10 presents the stop bit (`ps2_data_oe`=0).
  - After edge 10, go to ACK.
- **ACK**
  - On the next falling edge, sample the synchronized data line.
  - 0 → go to WAIT_IDLE.
  - 1 → `error` pulse, go to IDLE.
- **WAIT_IDLE**
  - Wait until both synchronized lines are 1, then pulse `done` and go to IDLE.
- **Watchdog**
  - The counter clears on entry to SEND, ACK and WAIT_IDLE, and on every falling edge.
  - When it reaches `TIMEOUT_CYCLES` in SEND, ACK or WAIT_IDLE: both `oe` = 0, `error` pulse, go to IDLE.
- **Output rules**
  - `done` and `error` are never high together.
  - Both `done` and `error` are issued in the cycle the state returns to IDLE; `busy` is 0 in that cycle.
  - A `start` in that same cycle is ignored.
  - `busy` = (state ≠ IDLE).
- **Counter widths:** `$clog2` of the largest parameter, plus 1. Bit counter is 4 bits.

## Timing
- **Reset:** asynchronous. All outputs 0, state IDLE, counters 0. Asserting reset mid-frame releases both lines immediately, without waiting for a clock edge.
- **Registered outputs:** all outputs are registered.
- **After `start` accepted (cycle T):**
  - `busy` and `ps2_clk_oe` are 1 from T+1.
  - `ps2_data_oe` rises at T+1+`INHIBIT_CYCLES`.
  - `ps2_clk_oe` falls at T+1+`INHIBIT_CYCLES`+`SETUP_CYCLES`.
- **Bit update latency:** a data-line change follows a `ps2_clk_in` falling edge by 3 cycles (2 sync + 1 register). This is well inside the ≥30 µs device clock-low phase.
- **Glitch filtering:** none beyond the synchronizer. The device clock is 10–16.7 kHz.

## Test plan
- **Send 0xED, device model ACKs.**
  - Device model runs a 12.5 kHz clock and samples on rising edges.
  - Sampled bits must be 0,1,0,1,1,0,1,1,1,1(parity),1(stop).
  - `done` pulses once, `busy` then falls, `error` stays 0.
- **Inhibit/setup timing with INHIBIT_CYCLES=10, SETUP_CYCLES=3.**
  - `start` at T gives `clk_oe` high over T+1..T+13, `data_oe` high from T+11, and `clk_oe` low at T+14.
- **Parity and NACK.**
  - 0x01 gives parity bit 0; 0x00 gives parity bit 1.
  - Device holds data high on the 11th falling edge → `error` pulse, both `oe` = 0, `done` never asserted.
- **Timeout with TIMEOUT_CYCLES=100.**
  - Device never clocks → `error` exactly 100 cycles after SEND entry, return to IDLE.
  - A second `start` then completes normally.
- **Reset mid-frame.**
  - Assert `reset` after the 5th falling edge → `ps2_clk_oe` = `ps2_data_oe` = `busy` = 0 asynchronously, with no `done`/`error`.
  - A new 0xFF transfer then succeeds.
- **`start` while busy.**
  - Pulse `start` with 0x55 during SEND of 0xF4 → frame carries 0xF4 only, and exactly one `done`.
